dtube_decoder: RTL
==================

# dtube_decoder

Seven-segment scan receiver. Samples the multiplexed `dtube_cs_n`/`dtube_data` bus driven by the board-level display scanner and de-scans it back into a 16-bit hex value plus per-digit decimal points and blank flags. It sits beside the display driver as the opposite end of the same interface. Its purpose is on-board readback and self-checking benches: it turns what the display shows into values that can be compared directly.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is captured (≥2).
- `TIMEOUT_CYCLES`, 65536: cycles with no capture before the partial frame is discarded.
- `ext_clk_25m` input 1: single system clock, rising edge.
- `ext_rst_n` input 1: asynchronous, active-low reset.
- `dtube_cs_n` input 4: digit select, active-low; bit k selects digit k (digit 0 = least significant nibble).
- `dtube_data` input 8: segments, active-low; bit0=a … bit6=g, bit7=dp.
- `value` output 16: last complete frame, `{d3,d2,d1,d0}`.
- `dp` output 4: decimal point lit, per digit, last complete frame.
- `blank` output 4: digit was all-off, per digit, last complete frame.
- `value_valid` output 1: one-cycle pulse when `value`/`dp`/`blank` update.
- `digit_err` output 1: one-cycle pulse, unrecognised segment pattern.
- `scan_err` output 1: one-cycle pulse on select overlap or timeout.

## Operation
- All inputs are registered once. All further logic uses the registered copy.
- Lit mask: `L = ~dtube_data[6:0]`. Decode table for L:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - 00: blank, nibble 0.
- Select classification:
  - Exactly one `cs_n` bit low: active digit k.
  - None low: idle, no capture.
  - More than one low: overlap. `scan_err` pulses once per entry into overlap. No capture.
- Stability counter:
  - Counts consecutive edges at which the registered `{cs_n,data}` is unchanged.
  - Resets on any change.
  - Saturates; it does not re-fire during a long dwell, so there is exactly one capture per dwell.
- Capture of digit k:
  - Pattern in table: `shadow[k]` ← nibble, dp bit, blank flag; set `seen[k]`; clear timeout counter.
  - Pattern not in table: `digit_err` pulses; shadow and seen unchanged.
  - Recapture of an already-seen digit overwrites its shadow without error.
- Frame publish:
  - Triggered one edge after `seen` becomes 4'b1111.
  - `value`/`dp`/`blank` ← shadow, `value_valid`=1, `seen` cleared.
  - A capture on the same edge sets its `seen` bit for the new frame (capture wins over clear for that bit).
- Timeout:
  - Timeout counter reaches `TIMEOUT_CYCLES` with `seen` ≠ 0: `scan_err` pulses, `seen` cleared, counter restarts.
  - Counter is held at 0 while `seen` = 0.
- Error precedence: `digit_err` and `scan_err` are independent and may pulse on the same edge.

## Timing
- Reset values: `value`=0, `dp`=0, `blank`=0, `value_valid`=0, `digit_err`=0, `scan_err`=0; `seen`=0, shadow=0, all counters 0.
- Reset is asynchronous and takes effect mid-frame. The partial frame is discarded and the last published value is lost.
- Capture latency: input stable at the pins across edges E0..E(STABLE_CYCLES-1) is captured at edge E(STABLE_CYCLES). For the default 4: held at edges 0–3, shadow written at edge 4.
- `value_valid` and outputs change at the edge after the completing capture; for the default that is edge 5 relative to the last digit's first sample.
- A digit dwell shorter than `STABLE_CYCLES` is silently ignored.

## Configuration
- `DTUBE_DP_EN` defined:
  - bit7 participates in the stability comparison.
  - Decoded into `dp`.
- `DTUBE_DP_EN` undefined:
  - bit7 is masked out of stability and decode.
  - `dp` is held at 4'b0000.

## Test plan
- Scan 0x12AF at 8 cycles/digit: cs_n=1110 data=8E, 1101/88, 1011/A4, 0111/F9 → `value`=0x12AF, `blank`=0, one `value_valid` pulse, no errors.
- Same scan, but digit 2 data=24 with `DTUBE_DP_EN` → `dp`=4'b0100. Without the macro → `dp`=0 and `value` unchanged at 0x12AF.
- Digit 1 data=FF → `blank`=4'b0010, `value`[7:4]=0. Digit 0 data=C1 (not in table) → `digit_err` pulse, no `value_valid` until a valid digit 0 follows.
- cs_n=1100 held 10 cycles → single `scan_err` pulse, no capture. Dwell of 3 cycles → no capture.
- Capture digits 0–2, then stop with cs_n=1111 → `scan_err` at `TIMEOUT_CYCLES` (set to 64 in the bench), `seen` cleared. Then a full scan of 0x0005 → `value`=0x0005.
- Assert reset after 3 digits captured → all outputs 0. Release, full scan of 0xBEEF → `value`=0xBEEF after exactly one `value_valid`.

Source files
------------

// File: rtl/dtube_decoder.sv
// dtube_decoder: de-scans a multiplexed 7-segment bus back into hex digits.
// Optional DTUBE_DP_EN: decode bit7 (decimal point) and include it in stability.
module dtube_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        ext_clk_25m,
   input  logic        ext_rst_n,
   input  logic [3:0]  dtube_cs_n,
   input  logic [7:0]  dtube_data,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic        value_valid,
   output logic        digit_err,
   output logic        scan_err
);

   localparam int SW = $clog2(STABLE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [SW-1:0] SMAX  = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] SFIRE = SW'(STABLE_CYCLES - 2);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    cs_q, cs_p;
   logic [7:0]    data_q, data_p;
   logic [7:0]    data_m;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic [3:0]    seen, seen_nx;
   logic [15:0]   sh_val;
   logic [3:0]    sh_dp, sh_blank;

   logic [3:0] sel, sel_p;
   logic       single, ovl, ovl_p;
   logic       same, fire, good, bad;
   logic       publish, tmo;
   logic       dp_bit;
   logic [1:0] idx;
   logic [5:0] dec;

   // returns {known, blank, nibble} for a lit-segment mask
   function automatic logic [5:0] seg_dec(input logic [6:0] l);
      logic [5:0] r;
      r = 6'b0;
      case (l)
         7'h3F: r = {2'b10, 4'h0};
         7'h06: r = {2'b10, 4'h1};
         7'h5B: r = {2'b10, 4'h2};
         7'h4F: r = {2'b10, 4'h3};
         7'h66: r = {2'b10, 4'h4};
         7'h6D: r = {2'b10, 4'h5};
         7'h7D: r = {2'b10, 4'h6};
         7'h07: r = {2'b10, 4'h7};
         7'h7F: r = {2'b10, 4'h8};
         7'h6F: r = {2'b10, 4'h9};
         7'h77: r = {2'b10, 4'hA};
         7'h7C: r = {2'b10, 4'hB};
         7'h39: r = {2'b10, 4'hC};
         7'h5E: r = {2'b10, 4'hD};
         7'h79: r = {2'b10, 4'hE};
         7'h71: r = {2'b10, 4'hF};
         7'h00: r = {2'b11, 4'h0};
         default: r = 6'b0;
      endcase
      return r;
   endfunction

`ifdef DTUBE_DP_EN
   assign data_m = dtube_data;
   assign dp_bit = ~data_q[7];
`else
   assign data_m = {1'b0, dtube_data[6:0]};
   assign dp_bit = 1'b0;
`endif

   assign sel   = ~cs_q;
   assign sel_p = ~cs_p;
   assign single = $onehot(sel);
   assign ovl    = (sel & (sel - 4'd1)) != 4'd0;
   assign ovl_p  = (sel_p & (sel_p - 4'd1)) != 4'd0;
   assign same   = {cs_q, data_q} == {cs_p, data_p};
   assign fire   = same && (scnt == SFIRE) && single;
   assign dec    = seg_dec(~data_q[6:0]);
   assign good   = fire && dec[5];
   assign bad    = fire && !dec[5];
   assign publish = (seen == 4'hF);
   assign tmo    = (seen != 4'd0) && !publish && !good && (tcnt == TLAST);

   // active digit index from the registered select
   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) idx = 2'(i);
      end
   end

   // next seen mask: capture wins over publish/timeout clear
   always_comb begin
      seen_nx = (publish || tmo) ? 4'd0 : seen;
      if (good) seen_nx[idx] = 1'b1;
   end

   // input sampling plus one-cycle history for change detection
   always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         cs_q   <= 4'hF;
         data_q <= 8'h00;
         cs_p   <= 4'hF;
         data_p <= 8'h00;
      end else begin
         cs_q   <= dtube_cs_n;
         data_q <= data_m;
         cs_p   <= cs_q;
         data_p <= data_q;
      end
   end

   // saturating stability counter, one capture per dwell
   always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         scnt <= '0;
      end else if (!same) begin
         scnt <= '0;
      end else if (scnt != SMAX) begin
         scnt <= scnt + 1'b1;
      end
   end

   // shadow digits, seen mask and frame timeout
   always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         sh_val   <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         seen     <= '0;
         tcnt     <= '0;
      end else begin
         seen <= seen_nx;
         if (good) begin
            sh_val[{idx, 2'b00} +: 4] <= dec[3:0];
            sh_dp[idx]    <= dp_bit;
            sh_blank[idx] <= dec[4];
         end
         if (seen == 4'd0 || good || tmo) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   // published frame and status pulses
   always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         value       <= '0;
         dp          <= '0;
         blank       <= '0;
         value_valid <= 1'b0;
         digit_err   <= 1'b0;
         scan_err    <= 1'b0;
      end else begin
         value_valid <= publish;
         digit_err   <= bad;
         scan_err    <= (ovl && !ovl_p) || tmo;
         if (publish) begin
            value <= sh_val;
            dp    <= sh_dp;
            blank <= sh_blank;
         end
      end
   end

endmodule
